// File: rtl/rv_ifetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel,
// redirect input from execute, and the valid/ready channel to decode.
interface rv_ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ctrl;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc, id_ctrl,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  // Environment side: memory, execute and decode
  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc, id_ctrl,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/rv_ifetch.sv
// RV32I instruction fetch stage: owns the fetch PC, keeps up to DEPTH
// in-order requests in flight, buffers returned words with their PCs and
// a control-transfer predecode bit, and flushes on redirect from execute.
module rv_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  rv_ifetch_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  // Major opcodes (inst[6:2]) of the control-transfer instructions
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  function automatic logic is_ctrl(input logic [31:0] inst);
    return (inst[6:2] == OP_BRANCH) || (inst[6:2] == OP_JAL) || (inst[6:2] == OP_JALR);
  endfunction

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          started;

  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic          fifo_ctrl [DEPTH];

  logic          redir;
  logic [31:0]   target;
  logic [CW:0]   used;
  logic          req;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          drop;
  logic          pop;
  logic          unused_pc_bits;

  assign redir  = bus.redirect_valid;
  // Redirect targets are word-aligned; the low bits are ignored.
  assign target = {bus.redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  // Credit counts buffered words plus words still in flight, so a response
  // always finds a free FIFO slot. A pop frees credit only from the next cycle.
  assign used  = {1'b0, count} + {1'b0, outstanding};
  assign req   = started & ~redir & (used < DEPTH_C);
  assign grant = req & bus.imem_gnt;
  assign rsp   = bus.imem_rvalid;
  assign push  = rsp & ~redir & (discard == '0);
  assign drop  = rsp & ~redir & (discard != '0);
  assign pop   = bus.id_valid & bus.id_ready;

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.id_valid  = (count != '0) & ~redir;
  assign bus.id_inst   = fifo_inst[rd_ptr];
  assign bus.id_pc     = fifo_pc[rd_ptr];
  assign bus.id_ctrl   = fifo_ctrl[rd_ptr];

  // Control state: PCs, in-flight/discard counters, FIFO pointers; redirect wins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redir) begin
        // Everything still in flight after this cycle belongs to the old stream.
        fetch_pc    <= target;
        rsp_pc      <= target;
        outstanding <= outstanding - CW'(rsp);
        discard     <= outstanding - CW'(rsp);
        count       <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push)  rsp_pc   <= rsp_pc + 32'd4;
        if (drop)  discard  <= discard - CW'(1);
        if (push)  wr_ptr   <= wr_ptr + AW'(1);
        if (pop)   rd_ptr   <= rd_ptr + AW'(1);
        outstanding <= outstanding + CW'(grant) - CW'(rsp);
        count       <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Buffer storage: written on push only, needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= rsp_pc;
      fifo_inst[wr_ptr] <= bus.imem_rdata;
      fifo_ctrl[wr_ptr] <= is_ctrl(bus.imem_rdata);
    end
  end

endmodule
